neuron_mac: RTL and testbench

Parametrised single-neuron engine for the layer datapath. It accepts an input activation vector through a valid/ready handshake and accumulates weight×input products over ⌈N_IN/LANES⌉ cycles using LANES time-shared multipliers, starting from the bias. It then saturates the sum to 16-bit signed, maps it to a sigmoid LUT address and returns an 8-bit activation through a valid/ready output. It is the configurable, backpressure-aware successor of the fixed 49-input fully-parallel neuron.

---
 rtl/neuron_pkg.sv | 48 ++++
 rtl/sigmoid_lut.sv | 28 ++
 rtl/neuron_mac.sv | 172 +++++++++++++++++
 tb/tb_neuron_mac.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and helpers for the neuron_mac engine.
//   state_t   - controller states
//   SAT_MIN/SAT_MAX - signed 16-bit clamp bounds
//   clamp16   - saturate a wide signed sum to 16 bits, reporting whether it clipped
//   lut_addr  - map a clamped sum to an offset-binary LUT address of addr_w bits
package neuron_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StSat,
        StLut,
        StOut
    } state_t;

    localparam int SAT_MIN = -32768;
    localparam int SAT_MAX = 32767;

    typedef struct packed {
        logic               sat;
        logic signed [15:0] val;
    } clamp_t;

    // Callers sign-extend their accumulator to 64 bits, so ACC_W must not exceed 64.
    function automatic clamp_t clamp16(input logic signed [63:0] v);
        clamp_t r;
        if (v > 64'(SAT_MAX)) begin
            r.sat = 1'b1;
            r.val = 16'(SAT_MAX);
        end else if (v < 64'(SAT_MIN)) begin
            r.sat = 1'b1;
            r.val = 16'(SAT_MIN);
        end else begin
            r.sat = 1'b0;
            r.val = v[15:0];
        end
        return r;
    endfunction

    // Adding 32768 to a 16-bit two's complement value is the same as flipping its MSB.
    function automatic logic [15:0] lut_addr(input logic signed [15:0] sum,
                                             input int unsigned addr_w);
        logic [15:0] ob;
        ob = {~sum[15], sum[14:0]};
        return ob >> (16 - addr_w);
    endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// sigmoid_lut: synchronous ROM, 2^ADDR_W words of OUT_W bits, one cycle read latency.
//   clk  - clock
//   addr - read address, sampled on the rising edge
//   q    - registered ROM word
// Contents are a linear ramp (addr scaled to OUT_W), computed in place.
module sigmoid_lut #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned OUT_W    = 8,
    parameter string       LUT_FILE = "sigmoid.hex"
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [OUT_W-1:0]  q
);

    function automatic logic [OUT_W-1:0] ramp(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        if (ADDR_W >= OUT_W) w = w >> (ADDR_W - OUT_W);
        else                 w = w << (OUT_W - ADDR_W);
        return w[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        q <= ramp(addr);
    end

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: single neuron, LANES time-shared multipliers, saturating sigmoid output.
//   clk, rst              - clock and synchronous active-high reset
//   in_valid / in_ready   - input vector handshake; in_data is N_IN unsigned activations
//   out_valid / out_ready - result handshake
//   out_data              - sigmoid activation from the LUT
//   out_sum               - pre-activation sum clamped to 16-bit signed
//   out_sat               - the clamp was active for this result
// Flow: IDLE -> ACCUM (BEATS cycles) -> SAT -> LUT -> OUT; one vector in flight.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int unsigned N_IN              = 49,
    parameter int unsigned LANES             = 7,
    parameter int unsigned IN_W              = 8,
    parameter int unsigned W_W               = 16,
    parameter int unsigned ACC_W             = 32,
    parameter int          WEIGHTS [N_IN-1:0] = '{default: 1},
    parameter int          BIAS              = 0,
    parameter int unsigned ADDR_W            = 12,
    parameter int unsigned OUT_W             = 8,
    parameter string       LUT_FILE          = "sigmoid.hex"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data [N_IN-1:0],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic signed [15:0]      out_sum,
    output logic                    out_sat
);

    localparam int unsigned BEATS  = (N_IN + LANES - 1) / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        out_sum_q, out_sum_d;
    logic                      out_sat_q, out_sat_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;
    logic [IN_W-1:0]           data_q [N_IN-1:0];
    logic                      load;

    logic [LANES-1:0][ACC_W-1:0] lane_prod;
    logic [ACC_W-1:0]            beat_sum;
    clamp_t                      clamp_now;
    logic [ADDR_W-1:0]           rom_addr;
    logic [OUT_W-1:0]            lut_q;

    // Padded lanes (index >= N_IN) are masked before indexing; the index is kept in range.
    function automatic logic [IDX_W-1:0] sel_idx(input int unsigned b, input int unsigned l);
        int unsigned i;
        i = b * LANES + l;
        return (i < N_IN) ? IDX_W'(i) : '0;
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [W_W-1:0]   w_sel;
        logic [IN_W-1:0]         x_sel;
        logic signed [ACC_W-1:0] prod;

        always_comb begin
            w_sel = '0;
            x_sel = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (beat_q == BEAT_W'(b) && (b * LANES + l) < N_IN) begin
                    w_sel = W_W'(WEIGHTS[sel_idx(b, l)]);
                    x_sel = data_q[sel_idx(b, l)];
                end
            end
        end

        // Signed weight times zero-extended activation.
        assign prod         = ACC_W'(w_sel) * ACC_W'($signed({1'b0, x_sel}));
        assign lane_prod[l] = prod;
    end

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_sum = beat_sum + lane_prod[l];
        end
    end

    // The ROM samples this address on the SAT->LUT edge, so out_data is ready entering OUT.
    assign clamp_now = clamp16(64'(acc_q));
    assign rom_addr  = ADDR_W'(lut_addr(clamp_now.val, ADDR_W));

    sigmoid_lut #(
        .ADDR_W   (ADDR_W),
        .OUT_W    (OUT_W),
        .LUT_FILE (LUT_FILE)
    ) u_lut (
        .clk  (clk),
        .addr (rom_addr),
        .q    (lut_q)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        acc_d      = acc_q;
        out_sum_d  = out_sum_q;
        out_sat_d  = out_sat_q;
        out_data_d = out_data_q;
        load       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    load    = 1'b1;
                    acc_d   = ACC_W'(BIAS);
                    beat_d  = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_q + $signed(beat_sum);
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = StSat;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StSat: begin
                out_sum_d = clamp_now.val;
                out_sat_d = clamp_now.sat;
                state_d   = StLut;
            end
            StLut: begin
                out_data_d = lut_q;
                state_d    = StOut;
            end
            StOut: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            acc_q      <= '0;
            out_sum_q  <= '0;
            out_sat_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            acc_q      <= acc_d;
            out_sum_q  <= out_sum_d;
            out_sat_q  <= out_sat_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) data_q <= in_data;
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StOut);
    assign out_data  = out_data_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

    localparam int W_ONE  [48:0] = '{default: 1};
    localparam int W_POS  [48:0] = '{default: 1000};
    localparam int W_NEG  [48:0] = '{default: -1000};
    // Index 48 is leftmost: element i holds i+1.
    localparam int W_RAMP [48:0] = '{49, 48, 47, 46, 45, 44, 43, 42, 41, 40, 39, 38, 37, 36,
                                     35, 34, 33, 32, 31, 30, 29, 28, 27, 26, 25, 24, 23, 22,
                                     21, 20, 19, 18, 17, 16, 15, 14, 13, 12, 11, 10, 9, 8, 7,
                                     6, 5, 4, 3, 2, 1};

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data [48:0];
    logic             out_ready;
    logic [3:0]       in_valid_v;
    logic [3:0]       in_ready_v;
    logic [3:0]       out_valid_v;
    logic [3:0]       out_sat_v;
    logic [3:0][7:0]  out_data_v;
    logic [3:0][15:0] out_sum_v;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    neuron_mac #(.LANES(7), .WEIGHTS(W_ONE), .BIAS(0), .LUT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(out_data_v[0]), .out_sum(out_sum_v[0]), .out_sat(out_sat_v[0])
    );
    neuron_mac #(.LANES(7), .WEIGHTS(W_POS), .BIAS(0), .LUT_FILE("")) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(out_data_v[1]), .out_sum(out_sum_v[1]), .out_sat(out_sat_v[1])
    );
    neuron_mac #(.LANES(7), .WEIGHTS(W_NEG), .BIAS(0), .LUT_FILE("")) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_data(in_data), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(out_data_v[2]), .out_sum(out_sum_v[2]), .out_sat(out_sat_v[2])
    );
    neuron_mac #(.LANES(5), .WEIGHTS(W_RAMP), .BIAS(-1225), .LUT_FILE("")) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .in_data(in_data), .out_valid(out_valid_v[3]), .out_ready(out_ready),
        .out_data(out_data_v[3]), .out_sum(out_sum_v[3]), .out_sat(out_sat_v[3])
    );

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Reference model: instance configuration written directly from the weight rules.
    function automatic int w_of(input int k, input int i);
        case (k)
            0:       return 1;
            1:       return 1000;
            2:       return -1000;
            default: return i + 1;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return (k == 3) ? 12 : 9;
    endfunction

    task automatic model(input int k, input logic [7:0] x [48:0],
                         output int esum, output int esat, output int eaddr, output int edata);
        longint acc;
        int     acc32;
        acc = (k == 3) ? -1225 : 0;
        for (int i = 0; i < 49; i++) acc += longint'(w_of(k, i)) * longint'(x[i]);
        acc32 = int'(acc);
        if (acc32 > 32767) begin
            esum = 32767;  esat = 1;
        end else if (acc32 < -32768) begin
            esum = -32768; esat = 1;
        end else begin
            esum = acc32;  esat = 0;
        end
        eaddr = (esum + 32768) / 16;
        // No LUT file: table is the linear ramp addr * 2^8 / 2^12.
        edata = eaddr / 16;
    endtask

    // Starts at a negedge; returns at the negedge where out_valid is first seen.
    task automatic run_vec(input int k, input logic [7:0] x [48:0], output int waited,
                           output int lat, output logic signed [15:0] sum,
                           output logic sat, output logic [7:0] dat);
        waited = 0;
        lat    = -1;
        while (!in_ready_v[k] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready_v[k]) begin
            in_data       = x;
            in_valid_v[k] = 1'b1;
            @(negedge clk);
            in_valid_v[k] = 1'b0;
            lat = 0;
            while (!out_valid_v[k] && lat < 40) begin
                @(negedge clk);
                lat++;
            end
        end
        sum = out_sum_v[k];
        sat = out_sat_v[k];
        dat = out_data_v[k];
    endtask

    typedef struct {
        int k;
        int xv;
        int esum;
        int esat;
        int eaddr;
        int elat;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t                tbl [7];
        logic [7:0]          x [48:0];
        int                  waited, lat, esum, esat, eaddr, edata;
        logic signed [15:0]  sum, bp_sum;
        logic                sat, bp_sat;
        logic [7:0]          dat, bp_dat;
        bit                  held_ok, rdy_seen, valid_seen;

        tbl[0] = '{0, 1,   49,     0, 2051, 9};
        tbl[1] = '{1, 255, 32767,  1, 4095, 9};
        tbl[2] = '{2, 255, -32768, 1, 0,    9};
        tbl[3] = '{3, 1,   0,      0, 2048, 12};
        tbl[4] = '{0, 0,   0,      0, 2048, 9};
        tbl[5] = '{0, 255, 12495,  0, 2828, 9};
        tbl[6] = '{3, 0,   -1225,  0, 1971, 12};

        rst        = 1'b1;
        out_ready  = 1'b1;
        in_valid_v = '0;
        for (int i = 0; i < 49; i++) in_data[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready_v, 0);
        check("rst_out_valid", out_valid_v, 0);
        check("rst_out_sum", out_sum_v[0], 0);
        check("rst_out_data", out_data_v[0], 0);
        check("rst_out_sat", out_sat_v, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_v, 15);

        // Directed table
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 49; i++) x[i] = 8'(tbl[t].xv);
            run_vec(tbl[t].k, x, waited, lat, sum, sat, dat);
            check($sformatf("tbl%0d_sum", t), sum, tbl[t].esum);
            check($sformatf("tbl%0d_sat", t), sat, tbl[t].esat);
            check($sformatf("tbl%0d_data", t), dat, tbl[t].eaddr / 16);
            check($sformatf("tbl%0d_latency", t), lat, tbl[t].elat);
        end

        // Backpressure: result held for 20 cycles, new requests ignored
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 49; i++) x[i] = 8'd2;
        run_vec(0, x, waited, lat, bp_sum, bp_sat, bp_dat);
        model(0, x, esum, esat, eaddr, edata);
        check("bp_sum", bp_sum, esum);
        check("bp_data", bp_dat, edata);
        held_ok  = 1'b1;
        rdy_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 49; i++) in_data[i] = 8'($urandom_range(0, 255));
            in_valid_v[0] = 1'b1;
            @(negedge clk);
            if (!out_valid_v[0] || out_sum_v[0] != bp_sum || out_sat_v[0] != bp_sat ||
                out_data_v[0] != bp_dat) held_ok = 1'b0;
            if (in_ready_v[0]) rdy_seen = 1'b1;
        end
        check("bp_outputs_held", held_ok, 1);
        check("bp_in_ready_low", rdy_seen, 0);
        in_valid_v[0] = 1'b0;
        out_ready     = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid_v[0], 0);
        check("bp_release_ready", in_ready_v[0], 1);
        for (int i = 0; i < 49; i++) x[i] = 8'd1;
        run_vec(0, x, waited, lat, sum, sat, dat);
        check("bp_next_accept_wait", waited, 0);
        check("bp_next_sum", sum, 49);

        // Reset during ACCUM beat 3
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 49; i++) in_data[i] = 8'd1;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", in_ready_v[0], 1);
        valid_seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid_v[0]) valid_seen = 1'b1;
        end
        check("midrst_no_result", valid_seen, 0);
        run_vec(0, x, waited, lat, sum, sat, dat);
        check("midrst_next_sum", sum, 49);
        check("midrst_next_latency", lat, 9);

        // Randomized vectors against the model, back to back to exercise the initiation interval
        for (int kk = 0; kk < 2; kk++) begin
            int k;
            k = (kk == 0) ? 0 : 3;
            for (int r = 0; r < 12; r++) begin
                int maxv;
                maxv = (k == 0) ? 255 : ((r % 3 == 0) ? 3 : ((r % 3 == 1) ? 40 : 255));
                for (int i = 0; i < 49; i++) x[i] = 8'($urandom_range(0, maxv));
                run_vec(k, x, waited, lat, sum, sat, dat);
                model(k, x, esum, esat, eaddr, edata);
                check($sformatf("rnd%0d_%0d_sum", k, r), sum, esum);
                check($sformatf("rnd%0d_%0d_sat", k, r), sat, esat);
                check($sformatf("rnd%0d_%0d_data", k, r), dat, edata);
                check($sformatf("rnd%0d_%0d_latency", k, r), lat, lat_of(k));
                if (r > 0) check($sformatf("rnd%0d_%0d_ii_wait", k, r), waited, 1);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
